mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_mem_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_pkg
// Summary  : Shared types and defaults for the instruction/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    localparam int c_MEM_LAT_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Summary  : Two-way round-robin pick between fetch and data requesters.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import riscv_mem_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  grant_e last_gnt,
    output grant_e gnt
);

    // On contention the side that was not served last wins.
    always_comb begin
        gnt = GNT_D;
        if (req_i && req_d) begin
            gnt = (last_gnt == GNT_D) ? GNT_I : GNT_D;
        end else if (req_i) begin
            gnt = GNT_I;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Summary  : Shares one fixed-latency memory port between fetch and data sides.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int MEM_LAT = c_MEM_LAT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    output logic        m_en,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata,
    output logic        busy
);

    localparam logic [3:0] c_CNT_LAST = 4'(MEM_LAT - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    grant_e      r_gnt;
    grant_e      w_gnt;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [63:0] r_wdata;
    logic [31:0] r_i_rdata;
    logic [63:0] r_d_rdata;
    logic        r_m_en, r_m_wr, r_busy, r_i_ack, r_d_ack;
    logic        w_m_en_nxt, w_m_wr_nxt, w_busy_nxt, w_i_ack_nxt, w_d_ack_nxt;
    logic        w_any_req, w_grant, w_last_beat;

    assign w_any_req   = i_req | d_req;
    assign w_grant     = (r_state == IDLE) && w_any_req;
    assign w_last_beat = (r_state == ACCESS) && (r_cnt == c_CNT_LAST);

    // r_gnt doubles as the round-robin pointer; reset value makes D win first.
    rr_arb2 u_rr_arb2 (
        .req_i    (i_req),
        .req_d    (d_req),
        .last_gnt (r_gnt),
        .gnt      (w_gnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = ACCESS;
            ACCESS:  if (w_last_beat) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_m_en_nxt  = (w_state_nxt == ACCESS);
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_i_ack_nxt = (w_state_nxt == DONE) && (r_gnt == GNT_I);
        w_d_ack_nxt = (w_state_nxt == DONE) && (r_gnt == GNT_D);
        w_m_wr_nxt  = 1'b0;
        if (w_grant) begin
            w_m_wr_nxt = (w_gnt == GNT_D) && d_we;
        end else if ((r_state == ACCESS) && !w_last_beat) begin
            w_m_wr_nxt = r_m_wr;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_m_en  <= 1'b0;
            r_m_wr  <= 1'b0;
            r_busy  <= 1'b0;
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
        end else begin
            r_m_en  <= w_m_en_nxt;
            r_m_wr  <= w_m_wr_nxt;
            r_busy  <= w_busy_nxt;
            r_i_ack <= w_i_ack_nxt;
            r_d_ack <= w_d_ack_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_gnt     <= GNT_I;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if ((r_state == ACCESS) && !w_last_beat) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= '0;
            end
            if (w_grant) begin
                r_gnt   <= w_gnt;
                r_addr  <= (w_gnt == GNT_I) ? i_addr : d_addr;
                r_wdata <= d_wdata;
            end
            // Stores leave the load data untouched.
            if (w_last_beat && !r_m_wr) begin
                if (r_gnt == GNT_D) begin
                    r_d_rdata <= m_rdata;
                end else begin
                    r_i_rdata <= r_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
                end
            end
        end
    end

    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign m_en    = r_m_en;
    assign m_wr    = r_m_wr;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_arbiter
// Summary  : Directed scoreboard bench for mem_arbiter at MEM_LAT=2 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr;
    logic [63:0] d_wdata, m_rdata;
    logic        i_ack, d_ack, m_en, m_wr, busy;
    logic [31:0] i_rdata, m_addr;
    logic [63:0] d_rdata, m_wdata;

    logic        l1_i_req;
    logic [31:0] l1_i_addr;
    logic [63:0] l1_m_rdata;
    logic        l1_i_ack, l1_d_ack, l1_m_en, l1_m_wr, l1_busy;
    logic [31:0] l1_i_rdata, l1_m_addr;
    logic [63:0] l1_d_rdata, l1_m_wdata;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
        int          at;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   t;

    mem_arbiter #(.MEM_LAT(2)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(64'd0),
        .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
        .m_en(l1_m_en), .m_wr(l1_m_wr), .m_addr(l1_m_addr), .m_wdata(l1_m_wdata),
        .m_rdata(l1_m_rdata), .busy(l1_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitors: every ack pops one expectation and checks port, timing and data.
    always @(negedge clock) begin
        if (i_ack || d_ack) begin
            if (sb0.size() == 0) begin
                chk("ack_unexpected", 128'({i_ack, d_ack}), 128'd0);
            end else begin
                e0 = sb0.pop_front();
                chk("ack_port", 128'({i_ack, d_ack}), e0.is_d ? 128'd1 : 128'd2);
                chk("ack_cycle", 128'(cyc), 128'(e0.at));
                chk("ack_rdata", e0.is_d ? 128'(d_rdata) : 128'(i_rdata), 128'(e0.data));
            end
        end
    end

    always @(negedge clock) begin
        if (l1_i_ack || l1_d_ack) begin
            if (sb1.size() == 0) begin
                chk("l1_ack_unexpected", 128'({l1_i_ack, l1_d_ack}), 128'd0);
            end else begin
                e1 = sb1.pop_front();
                chk("l1_ack_port", 128'({l1_i_ack, l1_d_ack}), e1.is_d ? 128'd1 : 128'd2);
                chk("l1_ack_cycle", 128'(cyc), 128'(e1.at));
                chk("l1_ack_rdata", 128'(l1_i_rdata), 128'(e1.data));
            end
        end
    end

    initial begin
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; m_rdata = '0;
        l1_i_req = 1'b0; l1_i_addr = '0; l1_m_rdata = '0;
        tick(2);
        chk("rst_ctrl", 128'({i_ack, d_ack, m_en, m_wr, busy}), 128'd0);
        chk("rst_m_addr", 128'(m_addr), 128'd0);
        chk("rst_m_wdata", 128'(m_wdata), 128'd0);
        chk("rst_rdata", 128'({i_rdata, d_rdata}), 128'd0);
        reset = 1'b1;
        tick(1);

        // Single fetch, upper half selected by addr[2]
        t = cyc;
        i_req = 1'b1; i_addr = 32'h4; m_rdata = 64'h11223344_55667788;
        sb0.push_back('{1'b0, 64'h11223344, t + 3});
        tick(1);
        chk("f_m_en1", 128'({m_en, m_wr, busy}), 128'b101);
        chk("f_m_addr", 128'(m_addr), 128'h4);
        tick(1);
        chk("f_m_en2", 128'(m_en), 128'd1);
        tick(1);
        chk("f_done_m_en", 128'({m_en, busy}), 128'b01);
        i_req = 1'b0;
        tick(1);
        chk("f_idle_busy", 128'(busy), 128'd0);

        // Contention right after reset: D, then I, then D again
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        t = cyc;
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        m_rdata = 64'hA5A50001_5A5A0002;
        sb0.push_back('{1'b1, 64'hA5A50001_5A5A0002, t + 3});
        sb0.push_back('{1'b0, 64'h5A5A0002, t + 7});
        sb0.push_back('{1'b1, 64'h0BADF00D_12345678, t + 11});
        tick(3);
        d_req = 1'b0;
        tick(1);
        d_req = 1'b1; d_addr = 32'h48;
        tick(1);
        chk("rr_m_addr_i", 128'(m_addr), 128'h8);
        tick(2);
        i_req = 1'b0;
        m_rdata = 64'h0BADF00D_12345678;
        tick(2);
        chk("rr_m_addr_d", 128'(m_addr), 128'h48);
        tick(2);
        d_req = 1'b0;
        tick(1);
        chk("rr_i_rdata_hold", 128'(i_rdata), 128'h5A5A0002);

        // Store with inputs changed mid-access
        t = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 64'hDEADBEEF_CAFEF00D;
        m_rdata = 64'h77777777_77777777;
        sb0.push_back('{1'b1, 64'h0BADF00D_12345678, t + 3});
        tick(1);
        chk("st_ctrl1", 128'({m_en, m_wr}), 128'b11);
        chk("st_m_addr1", 128'(m_addr), 128'h100);
        chk("st_m_wdata1", 128'(m_wdata), 128'hDEADBEEF_CAFEF00D);
        d_addr = 32'h200; d_wdata = 64'h0; d_we = 1'b0;
        tick(1);
        chk("st_ctrl2", 128'({m_en, m_wr}), 128'b11);
        chk("st_m_addr2", 128'(m_addr), 128'h100);
        chk("st_m_wdata2", 128'(m_wdata), 128'hDEADBEEF_CAFEF00D);
        tick(1);
        chk("st_done_ctrl", 128'({m_en, m_wr}), 128'b00);
        chk("st_done_addr", 128'(m_addr), 128'h100);
        d_req = 1'b0;
        tick(1);

        // Reset in the middle of a fetch aborts it
        i_req = 1'b1; i_addr = 32'hC; m_rdata = 64'hCAFE0000_BEEF0000;
        tick(1);
        chk("ab_m_en", 128'(m_en), 128'd1);
        #2 reset = 1'b0;
        #1;
        chk("ab_ctrl", 128'({m_en, m_wr, busy, i_ack, d_ack}), 128'd0);
        chk("ab_m_addr", 128'(m_addr), 128'd0);
        chk("ab_rdata", 128'({i_rdata, d_rdata}), 128'd0);
        i_req = 1'b0;
        tick(2);
        reset = 1'b1;
        t = cyc;
        i_req = 1'b1;
        sb0.push_back('{1'b0, 64'hCAFE0000, t + 3});
        tick(3);
        i_req = 1'b0;
        tick(2);

        // MEM_LAT=1 back-to-back fetches: ack every third cycle
        t = cyc;
        l1_i_req = 1'b1; l1_i_addr = 32'h0; l1_m_rdata = 64'h01234567_89ABCDEF;
        for (int k = 0; k < 3; k++) sb1.push_back('{1'b0, 64'h89ABCDEF, t + 2 + 3 * k});
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            chk("l1_m_en", 128'(l1_m_en), 128'((k % 3) == 1));
            if (k == 8) l1_i_req = 1'b0;
        end
        tick(3);

        chk("ack_missing", 128'(sb0.size()), 128'd0);
        chk("l1_ack_missing", 128'(sb1.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
